// File: rtl/ts_pid_capture.sv
// ============================================================================
// Module   : ts_pid_capture
// Purpose  : Per-tuner TS ingest. Sync check, PID filter, ping-pong buffer
//            write and half announce. Optional macro TEI_DROP_EN also drops
//            packets whose transport_error_indicator is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_pid_capture #(
  parameter int NUM_PID = 8,
  parameter int PKT_LEN = 188
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ts_data,
  input  logic        ts_valid,
  input  logic        ts_sync,
  input  logic        pid_wr_en,
  input  logic [3:0]  pid_wr_addr,
  input  logic [13:0] pid_wr_data,
  input  logic        buf_rel,
  output logic [8:0]  buf_wadd,
  output logic [7:0]  buf_wdata,
  output logic        buf_wen,
  output logic        lend_p,
  output logic        lpid_fd,
  output logic        lbuffer_h,
  output logic [11:0] lpid_i,
  output logic        ovf,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_CAPT = 2'd1,
    S_SKIP = 2'd2
  } state_t;

  localparam logic [7:0] c_sync_byte = 8'h47;
  localparam logic [7:0] c_last      = 8'(PKT_LEN - 1);

  state_t      r_state, w_state_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic [12:0] r_pid, w_pid_nx;
  logic        r_drop, w_drop_nx;
  logic        w_wen_nx, w_ovf_nx, w_serr_nx, w_complete;
  logic [8:0]  w_wadd_nx;
  logic [7:0]  w_wdata_nx;

  logic        r_tab_en  [NUM_PID];
  logic [12:0] r_tab_pid [NUM_PID];
  logic [NUM_PID-1:0] w_match;
  logic [12:0] w_pid_cmp;
  logic        w_hit;

  logic [1:0]  r_busy, w_busy_nx;
  logic        r_wr_half;
  logic        r_ann_out, r_slot_vld, r_slot_half;
  logic [11:0] r_slot_pid;
  logic        w_out_eff, w_ann, w_rel;
  logic        w_sync_evt;

  // Byte 2 compares against the registered table, so a same-cycle write
  // is only seen by the following packet.
  assign w_pid_cmp = {r_pid[12:8], ts_data};

  generate
    for (genvar gi = 0; gi < NUM_PID; gi++) begin : g_tab
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tab_en[gi]  <= 1'b0;
          r_tab_pid[gi] <= 13'd0;
        end else if (pid_wr_en && (pid_wr_addr == 4'(gi))) begin
          r_tab_en[gi]  <= pid_wr_data[13];
          r_tab_pid[gi] <= pid_wr_data[12:0];
        end
      end
      assign w_match[gi] = r_tab_en[gi] && (r_tab_pid[gi] == w_pid_cmp);
    end
  endgenerate

  assign w_hit = |w_match;

  // A sync byte inside a packet aborts it and restarts the hunt on this byte.
  assign w_sync_evt = ts_valid && ts_sync && ((r_state == S_HUNT) || (r_cnt != 8'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HUNT;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pid_nx   = r_pid;
    w_drop_nx  = r_drop;
    w_wen_nx   = 1'b0;
    w_wadd_nx  = buf_wadd;
    w_wdata_nx = buf_wdata;
    w_ovf_nx   = 1'b0;
    w_serr_nx  = 1'b0;
    w_complete = 1'b0;
    if (w_sync_evt) begin
      if (r_state != S_HUNT) w_serr_nx = 1'b1;
      if (ts_data != c_sync_byte) begin
        w_serr_nx  = 1'b1;
        w_state_nx = S_HUNT;
        w_cnt_nx   = 8'd0;
      end else if (r_busy[r_wr_half]) begin
        w_ovf_nx   = 1'b1;
        w_cnt_nx   = 8'd1;
        w_state_nx = S_SKIP;
      end else begin
        w_wen_nx   = 1'b1;
        w_wadd_nx  = {r_wr_half, 8'd0};
        w_wdata_nx = ts_data;
        w_cnt_nx   = 8'd1;
        w_drop_nx  = 1'b0;
        w_state_nx = S_CAPT;
      end
    end else if (ts_valid) begin
      case (r_state)
        S_CAPT: begin
          w_wen_nx   = 1'b1;
          w_wadd_nx  = {r_wr_half, r_cnt};
          w_wdata_nx = ts_data;
          w_cnt_nx   = r_cnt + 8'd1;
          if (r_cnt == 8'd1) begin
            w_pid_nx[12:8] = ts_data[4:0];
`ifdef TEI_DROP_EN
            if (ts_data[7]) w_drop_nx = 1'b1;
`endif
          end
          if (r_cnt == 8'd2) begin
            w_pid_nx[7:0] = ts_data;
            w_drop_nx     = r_drop | ~w_hit;
          end
          if (r_cnt == c_last) begin
            w_complete = ~r_drop;
            w_cnt_nx   = 8'd0;
            w_state_nx = S_HUNT;
          end
        end
        S_SKIP: begin
          w_cnt_nx = r_cnt + 8'd1;
          if (r_cnt == c_last) begin
            w_cnt_nx   = 8'd0;
            w_state_nx = S_HUNT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_pid     <= 13'd0;
      r_drop    <= 1'b0;
      buf_wen   <= 1'b0;
      buf_wadd  <= 9'd0;
      buf_wdata <= 8'd0;
      ovf       <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nx;
      r_pid     <= w_pid_nx;
      r_drop    <= w_drop_nx;
      buf_wen   <= w_wen_nx;
      buf_wadd  <= w_wadd_nx;
      buf_wdata <= w_wdata_nx;
      ovf       <= w_ovf_nx;
      sync_err  <= w_serr_nx;
    end
  end

  // Release of the outstanding half lets a pending slot go out on the same edge.
  assign w_rel     = buf_rel & r_ann_out;
  assign w_out_eff = r_ann_out & ~buf_rel;
  assign w_ann     = r_slot_vld & ~w_out_eff;

  always_comb begin
    w_busy_nx = r_busy;
    if (w_rel)      w_busy_nx[lbuffer_h] = 1'b0;
    if (w_complete) w_busy_nx[r_wr_half] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 2'b00;
      r_wr_half   <= 1'b0;
      r_ann_out   <= 1'b0;
      r_slot_vld  <= 1'b0;
      r_slot_half <= 1'b0;
      r_slot_pid  <= 12'd0;
      lend_p      <= 1'b0;
      lpid_fd     <= 1'b0;
      lbuffer_h   <= 1'b0;
      lpid_i      <= 12'd0;
    end else begin
      r_busy     <= w_busy_nx;
      r_ann_out  <= w_ann | w_out_eff;
      r_slot_vld <= w_complete | (r_slot_vld & ~w_ann);
      lend_p     <= w_ann;
      lpid_fd    <= w_ann;
      if (w_ann) begin
        lbuffer_h <= r_slot_half;
        lpid_i    <= r_slot_pid;
      end
      if (w_complete) begin
        r_slot_half <= r_wr_half;
        r_slot_pid  <= r_pid[11:0];
        r_wr_half   <= ~r_wr_half;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ts_pid_capture.sv
// ============================================================================
// Module   : tb_ts_pid_capture
// Purpose  : Directed vector bench for ts_pid_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ts_pid_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ts_data;
  logic        ts_valid, ts_sync;
  logic        pid_wr_en;
  logic [3:0]  pid_wr_addr;
  logic [13:0] pid_wr_data;
  logic        buf_rel;
  logic [8:0]  buf_wadd;
  logic [7:0]  buf_wdata;
  logic        buf_wen, lend_p, lpid_fd, lbuffer_h, ovf, sync_err;
  logic [11:0] lpid_i;

  ts_pid_capture #(.NUM_PID(8), .PKT_LEN(188)) dut (
    .clk(clk), .rst(rst), .ts_data(ts_data), .ts_valid(ts_valid), .ts_sync(ts_sync),
    .pid_wr_en(pid_wr_en), .pid_wr_addr(pid_wr_addr), .pid_wr_data(pid_wr_data),
    .buf_rel(buf_rel), .buf_wadd(buf_wadd), .buf_wdata(buf_wdata), .buf_wen(buf_wen),
    .lend_p(lend_p), .lpid_fd(lpid_fd), .lbuffer_h(lbuffer_h), .lpid_i(lpid_i),
    .ovf(ovf), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_wr = 0, n_ann = 0, n_ovf = 0, n_serr = 0, n_fd_bad = 0, n_wide = 0;
  int ann_cyc = 0, rel_cyc = 0;
  logic        ann_half = 1'b0, prev_lend = 1'b0;
  logic [11:0] ann_pid = 12'd0;
  logic [8:0]  wadd_log [0:8191];
  logic [7:0]  wdata_log [0:8191];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buf_wen) begin
      if (n_wr < 8192) begin
        wadd_log[n_wr]  = buf_wadd;
        wdata_log[n_wr] = buf_wdata;
      end
      n_wr = n_wr + 1;
    end
    if (lend_p) begin
      n_ann    = n_ann + 1;
      ann_half = lbuffer_h;
      ann_pid  = lpid_i;
      ann_cyc  = cyc;
      if (prev_lend) n_wide = n_wide + 1;
    end
    if (lpid_fd != lend_p) n_fd_bad = n_fd_bad + 1;
    prev_lend = lend_p;
    if (ovf)      n_ovf  = n_ovf + 1;
    if (sync_err) n_serr = n_serr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ts_valid = 1'b0; ts_sync = 1'b0; pid_wr_en = 1'b0; buf_rel = 1'b0;
    end
  endtask

  task automatic do_reset();
    ts_valid = 1'b0; ts_sync = 1'b0; ts_data = 8'd0; pid_wr_en = 1'b0;
    pid_wr_addr = 4'd0; pid_wr_data = 14'd0; buf_rel = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
  endtask

  task automatic prog(input logic [3:0] a, input logic [13:0] d);
    @(posedge clk); #1;
    pid_wr_en = 1'b1; pid_wr_addr = a; pid_wr_data = d;
    @(posedge clk); #1;
    pid_wr_en = 1'b0;
  endtask

  task automatic release_half();
    @(posedge clk); #1;
    buf_rel = 1'b1; rel_cyc = cyc;
    @(posedge clk); #1;
    buf_rel = 1'b0;
  endtask

  task automatic send_pkt(input logic [12:0] pid, input logic tei, input int nbytes,
                          input int wr_at, input logic [3:0] wa, input logic [13:0] wd);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      if (i == 0)      b = 8'h47;
      else if (i == 1) b = {tei, 2'b00, pid[12:8]};
      else if (i == 2) b = pid[7:0];
      else             b = 8'(i);
      @(posedge clk); #1;
      ts_valid = 1'b1; ts_sync = (i == 0); ts_data = b;
      pid_wr_en = (i == wr_at); pid_wr_addr = wa; pid_wr_data = wd;
    end
  endtask

  task automatic std_table();
    prog(4'd0, {1'b1, 13'h0100});
    prog(4'd3, {1'b1, 13'h1ABC});
    prog(4'd7, {1'b0, 13'h0300});
  endtask

  typedef struct {
    logic [12:0] pid;
    logic        tei;
    logic        exp_ann;
    logic        exp_half;
    logic [11:0] exp_lpid;
  } vec_t;

  vec_t vecs [8];
  int a0, w0, o0, s0;

  initial begin
    vecs[0] = '{13'h0100, 1'b0, 1'b1, 1'b0, 12'h100};
    vecs[1] = '{13'h0200, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{13'h0100, 1'b0, 1'b1, 1'b1, 12'h100};
    vecs[3] = '{13'h1ABC, 1'b0, 1'b1, 1'b0, 12'hABC};
    vecs[4] = '{13'h0300, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{13'h0ABC, 1'b0, 1'b0, 1'b0, 12'h000};
`ifdef TEI_DROP_EN
    vecs[6] = '{13'h0100, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[7] = '{13'h0100, 1'b0, 1'b1, 1'b1, 12'h100};
`else
    vecs[6] = '{13'h0100, 1'b1, 1'b1, 1'b1, 12'h100};
    vecs[7] = '{13'h0100, 1'b0, 1'b1, 1'b0, 12'h100};
`endif

    do_reset();
    check("rst_outputs", {23'd0, buf_wen, lend_p, lpid_fd, lbuffer_h, ovf, sync_err}, 32'd0);
    check("rst_wadd", {23'd0, buf_wadd}, 32'd0);
    check("rst_lpid", {20'd0, lpid_i}, 32'd0);

    std_table();
    for (int i = 0; i < 8; i++) begin
      a0 = n_ann; w0 = n_wr;
      send_pkt(vecs[i].pid, vecs[i].tei, 188, -1, 4'd0, 14'd0);
      idle(4);
      check($sformatf("v%0d_ann", i), n_ann - a0, {31'd0, vecs[i].exp_ann});
      if (vecs[i].exp_ann) begin
        check($sformatf("v%0d_half", i), {31'd0, ann_half}, {31'd0, vecs[i].exp_half});
        check($sformatf("v%0d_lpid", i), {20'd0, ann_pid}, {20'd0, vecs[i].exp_lpid});
        check($sformatf("v%0d_nwr", i), n_wr - w0, 32'd188);
        check($sformatf("v%0d_first", i), {23'd0, wadd_log[w0]}, {23'd0, vecs[i].exp_half, 8'h00});
        check($sformatf("v%0d_last", i), {23'd0, wadd_log[w0+187]}, {23'd0, vecs[i].exp_half, 8'hBB});
        check($sformatf("v%0d_data2", i), {24'd0, wdata_log[w0+2]}, {19'd0, vecs[i].pid[7:0]});
        release_half();
        idle(2);
      end
    end

    // Three packets without release: announce, pending, overflow.
    do_reset();
    std_table();
    a0 = n_ann;
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("ovf_p1_ann", n_ann - a0, 32'd1);
    check("ovf_p1_half", {31'd0, ann_half}, 32'd0);
    a0 = n_ann;
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("ovf_p2_pending", n_ann - a0, 32'd0);
    a0 = n_ann; w0 = n_wr; o0 = n_ovf;
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("ovf_p3_ovf", n_ovf - o0, 32'd1);
    check("ovf_p3_nwr", n_wr - w0, 32'd0);
    check("ovf_p3_ann", n_ann - a0, 32'd0);
    a0 = n_ann;
    release_half(); idle(3);
    check("rel_ann", n_ann - a0, 32'd1);
    check("rel_ann_cyc", ann_cyc - rel_cyc, 32'd1);
    check("rel_half", {31'd0, ann_half}, 32'd1);
    check("rel_lpid", {20'd0, ann_pid}, 32'h100);
    a0 = n_ann;
    release_half(); idle(3);
    check("rel2_noann", n_ann - a0, 32'd0);
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("after_ovf_ann", n_ann - a0, 32'd1);
    check("after_ovf_half", {31'd0, ann_half}, 32'd0);

    // Early sync at byte 100.
    do_reset();
    std_table();
    a0 = n_ann; w0 = n_wr; s0 = n_serr;
    send_pkt(13'h0100, 1'b0, 100, -1, 4'd0, 14'd0);
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0);
    idle(4);
    check("early_serr", n_serr - s0, 32'd1);
    check("early_ann", n_ann - a0, 32'd1);
    check("early_half", {31'd0, ann_half}, 32'd0);
    check("early_nwr", n_wr - w0, 32'd288);
    check("early_new_first", {23'd0, wadd_log[w0+100]}, 32'h000);
    check("early_new_last", {23'd0, wadd_log[w0+287]}, 32'h0BB);
    release_half(); idle(2);

    // Bad sync byte stays in HUNT.
    a0 = n_ann; w0 = n_wr; s0 = n_serr;
    @(posedge clk); #1; ts_valid = 1'b1; ts_sync = 1'b1; ts_data = 8'h46;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; ts_sync = 1'b0; ts_data = 8'(k + 1);
    end
    idle(4);
    check("badsync_serr", n_serr - s0, 32'd1);
    check("badsync_nwr", n_wr - w0, 32'd0);
    check("badsync_ann", n_ann - a0, 32'd0);
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("badsync_next_ann", n_ann - a0, 32'd1);
    check("badsync_next_half", {31'd0, ann_half}, 32'd1);
    release_half(); idle(2);

    // Table write coinciding with the byte-2 compare uses the old entry.
    a0 = n_ann;
    send_pkt(13'h0555, 1'b0, 188, 2, 4'd1, {1'b1, 13'h0555}); idle(4);
    check("race_old_value", n_ann - a0, 32'd0);
    send_pkt(13'h0555, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("race_new_ann", n_ann - a0, 32'd1);
    check("race_new_lpid", {20'd0, ann_pid}, 32'h555);
    check("race_new_half", {31'd0, ann_half}, 32'd0);
    release_half(); idle(2);

    // Reset mid-packet aborts and clears the table.
    a0 = n_ann;
    send_pkt(13'h0100, 1'b0, 50, -1, 4'd0, 14'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_wen", {31'd0, buf_wen}, 32'd0);
    ts_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    send_pkt(13'h0100, 1'b0, 188, -1, 4'd0, 14'd0); idle(4);
    check("midrst_noann", n_ann - a0, 32'd0);

    check("pulse_width", n_wide, 32'd0);
    check("lpid_fd_tracks", n_fd_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
